dram_responder: RTL and testbench
=================================

DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, data word width in bits.
REQ-002 The block SHALL expose parameter ADDR_LEN, default 32, byte-address width.
REQ-003 The block SHALL expose parameter DEPTH_WORDS, default 1024, memory depth in XLEN-bit words, power of two.
REQ-004 The block SHALL expose parameter WAIT_STATES, default 1, extra cycles inserted between accept and response (0..15).
REQ-005 The block SHALL expose parameter HEX_FILE, default "", preload image loaded at elaboration when non-empty (else contents zero).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-low.
REQ-008 req_valid  input  1  CPU-side request present.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_be  input  XLEN/8  byte-lane write enables.
REQ-012 dram_addr  input  ADDR_LEN  byte address; word index = dram_addr[ADDR_LEN-1:2].
REQ-013 dram_data_out  input  XLEN  write data from CPU.
REQ-014 dram_data_in  output  XLEN  read data to CPU.
REQ-015 rsp_valid  output  1  one-cycle response strobe.
REQ-016 rsp_err  output  1  qualified by rsp_valid; access out of range.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_we, req_be, dram_addr, dram_data_out SHALL be captured in that cycle and input changes afterwards ignored.
REQ-019 On accept: WAIT_STATES>0 -> WAIT with wait counter loaded to WAIT_STATES-1; WAIT_STATES=0 -> RESP directly.
REQ-020 In WAIT the counter SHALL decrement each cycle; at counter=0 the FSM SHALL go to RESP next edge.
REQ-021 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; accept-to-rsp_valid latency = WAIT_STATES+1 cycles; max throughput one request per WAIT_STATES+2 cycles.
REQ-022 A captured word index >= DEPTH_WORDS SHALL give rsp_err=1, dram_data_in=0, no memory change.
REQ-023 An in-range write SHALL update only lanes with req_be[i]=1 on the edge entering RESP; req_be=0 SHALL be a legal no-op write with rsp_err=0.
REQ-024 In-range write response SHALL drive dram_data_in=0.
REQ-025 In-range read SHALL drive dram_data_in with the full word contents during RESP, reflecting all previously completed writes; req_be ignored for reads.
REQ-026 dram_addr[1:0] SHALL be ignored (lane selection is solely by req_be).
REQ-027 Outside RESP, dram_data_in SHALL be 0, rsp_valid=0, rsp_err=0.
REQ-028 req_valid deasserted while not ready SHALL have no effect; no request is queued.

Reset
REQ-029 While rst=0 the FSM SHALL be IDLE, counter 0, req_ready=1 after release, rsp_valid=0, rsp_err=0, dram_data_in=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it: a pending write not yet committed SHALL NOT modify memory, and no response SHALL be issued.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 First accept SHALL be possible on the first rising edge after rst returns to 1.

Verification
REQ-033 WAIT_STATES=1: write addr 0x10, data 0xDEADBEEF, be=0xF at edge N -> rsp_valid=1 cycle N+2, rsp_err=0; read 0x10 -> dram_data_in=0xDEADBEEF.
REQ-034 Partial write: word 0x20 holds 0x11223344, write 0xAABBCCDD be=0x5 -> read returns 0x11BB33DD.
REQ-035 DEPTH_WORDS=1024: read addr 0x1000 -> rsp_err=1, dram_data_in=0; write addr 0x1000 -> rsp_err=1, word 0 unchanged.
REQ-036 WAIT_STATES=0 with req_valid held high for 4 transactions -> accepts every 2nd cycle, rsp_valid each cycle after accept, req_ready low in RESP.
REQ-037 WAIT_STATES=3: write 0x5A5A5A5A to 0x40, drop rst during WAIT -> no rsp_valid; after release read 0x40 returns previous value.
REQ-038 Change dram_addr/dram_data_out during WAIT -> response and memory reflect captured values only.

Source files
------------

// File: rtl/dram_responder.sv
// dram_responder: single-port word memory behind a valid/ready request port.
// One request is accepted at a time. The response follows WAIT_STATES+1
// cycles after the accept as a one-cycle rsp_valid strobe. Byte-lane writes
// are supported, and word indices at or beyond DEPTH_WORDS report rsp_err.
module dram_responder #(
  parameter int    XLEN        = 32,
  parameter int    ADDR_LEN    = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 1,
  parameter string HEX_FILE    = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [XLEN/8-1:0]   req_be,
  input  logic [ADDR_LEN-1:0] dram_addr,
  input  logic [XLEN-1:0]     dram_data_out,
  output logic [XLEN-1:0]     dram_data_in,
  output logic                rsp_valid,
  output logic                rsp_err
);

  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int IW = ADDR_LEN - 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  // Request fields captured at accept; later input changes are ignored.
  logic            we_q;
  logic [NB-1:0]   be_q;
  logic [AW-1:0]   widx_q;
  logic            oor_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [IW-1:0]   in_idx;
  logic            in_oor;
  logic            accept;
  logic            enter_resp;
  logic            cur_we;
  logic [NB-1:0]   cur_be;
  logic [AW-1:0]   cur_widx;
  logic            cur_oor;
  logic [XLEN-1:0] cur_wdata;
  logic            unused_addr_lsb;

  // The two address LSBs play no part; lanes are chosen by req_be alone.
  assign unused_addr_lsb = ^dram_addr[1:0];

  assign in_idx = dram_addr[ADDR_LEN-1:2];
  assign in_oor = (in_idx >= IW'(DEPTH_WORDS));
  assign accept = req_valid && (state_q == S_IDLE);

  // With zero wait states, the accept edge is also the RESP entry edge, so
  // the memory access has to use the live inputs instead of the captured copy.
  assign cur_we    = accept ? req_we            : we_q;
  assign cur_be    = accept ? req_be            : be_q;
  assign cur_widx  = accept ? in_idx[AW-1:0]    : widx_q;
  assign cur_oor   = accept ? in_oor            : oor_q;
  assign cur_wdata = accept ? dram_data_out     : wdata_q;
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // Memory image starts at zero. Reset never touches it.
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT x WAIT_STATES) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: everything is zero outside the single RESP cycle.
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    rsp_valid    = (state_q == S_RESP);
    rsp_err      = (state_q == S_RESP) && oor_q;
    dram_data_in = '0;
    if ((state_q == S_RESP) && !oor_q && !we_q) dram_data_in = rdata_q;
  end

  // Capture the request fields on accept (data path, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      be_q    <= req_be;
      widx_q  <= in_idx[AW-1:0];
      oor_q   <= in_oor;
      wdata_q <= dram_data_out;
    end
  end

  // Memory access on the edge entering RESP. The rst gate stops an
  // abandoned transaction from committing.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && !cur_oor) begin
      if (cur_we) begin
        for (int b = 0; b < NB; b++)
          if (cur_be[b]) mem[cur_widx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end else begin
        rdata_q <= mem[cur_widx];
      end
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder. Three instances with WAIT_STATES 0, 1 and 3 are
// driven by directed cases and random traffic, and each one is compared
// against a word-array reference model.
module tb_dram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst           [3];
  logic        req_valid     [3];
  logic        req_ready     [3];
  logic        req_we        [3];
  logic [3:0]  req_be        [3];
  logic [31:0] dram_addr     [3];
  logic [31:0] dram_data_out [3];
  logic [31:0] dram_data_in  [3];
  logic        rsp_valid     [3];
  logic        rsp_err       [3];

  dram_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_be(req_be[0]), .dram_addr(dram_addr[0]),
    .dram_data_out(dram_data_out[0]), .dram_data_in(dram_data_in[0]),
    .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]));

  dram_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_be(req_be[1]), .dram_addr(dram_addr[1]),
    .dram_data_out(dram_data_out[1]), .dram_data_in(dram_data_in[1]),
    .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]));

  dram_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_be(req_be[2]), .dram_addr(dram_addr[2]),
    .dram_data_out(dram_data_out[2]), .dram_data_in(dram_data_in[2]),
    .rsp_valid(rsp_valid[2]), .rsp_err(rsp_err[2]));

  // Reference memory contents, one image per instance.
  logic [31:0] model [3][1024];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic int ws(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One complete transaction. The caller must be at a negedge with the
  // instance idle. After the accept, the inputs are scrambled so that only
  // the captured values can influence the outcome.
  task automatic txn(input int k, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wd);
    logic        oor;
    logic [9:0]  idx;
    logic [31:0] exp;
    int          lat;
    oor = (addr[31:2] >= 30'd1024);
    idx = addr[11:2];
    exp = 32'h0;
    if (!oor) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[k][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp = model[k][idx];
      end
    end
    check($sformatf("ready_k%0d", k), 32'(req_ready[k]), 32'h1);
    req_valid[k]     = 1'b1;
    req_we[k]        = we;
    req_be[k]        = be;
    dram_addr[k]     = addr;
    dram_data_out[k] = wd;
    @(negedge clk);
    req_valid[k]     = 1'b0;
    req_we[k]        = 1'($urandom);
    req_be[k]        = 4'($urandom);
    dram_addr[k]     = $urandom;
    dram_data_out[k] = $urandom;
    lat = 1;
    while (!rsp_valid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_k%0d a=%h", k, addr), 32'(lat), 32'(ws(k) + 1));
    check($sformatf("err_k%0d a=%h", k, addr), 32'(rsp_err[k]), 32'(oor));
    check($sformatf("data_k%0d a=%h we=%0b", k, addr, we), dram_data_in[k], exp);
    @(negedge clk);
    check($sformatf("strobe_len_k%0d", k), 32'(rsp_valid[k]), 32'h0);
    check($sformatf("idle_data_k%0d", k), dram_data_in[k] | 32'(rsp_err[k]), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 1024; w++) model[k][w] = 32'h0;
      rst[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_be[k] = 4'h0;
      dram_addr[k] = 32'h0; dram_data_out[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_k%0d", k), 32'(rsp_valid[k]), 32'h0);
      check($sformatf("rst_err_k%0d", k), 32'(rsp_err[k]), 32'h0);
      check($sformatf("rst_data_k%0d", k), dram_data_in[k], 32'h0);
      rst[k] = 1'b1;
    end

    // The first request is issued in the cycle right after reset release.
    txn(1, 1'b0, 4'hF, 32'h10, 32'h0);
    txn(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    txn(1, 1'b0, 4'hF, 32'h10, 32'h0);
    // Partial writes, ignored address LSBs, and a no-op write with be=0.
    txn(1, 1'b1, 4'hF, 32'h20, 32'h11223344);
    txn(1, 1'b1, 4'h5, 32'h21, 32'hAABBCCDD);
    txn(1, 1'b0, 4'h0, 32'h22, 32'h0);
    txn(1, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF);
    txn(1, 1'b0, 4'hF, 32'h23, 32'h0);
    // Out-of-range accesses must leave word 0 intact.
    txn(1, 1'b1, 4'hF, 32'h0, 32'h01020304);
    txn(1, 1'b0, 4'hF, 32'h1000, 32'h0);
    txn(1, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
    txn(1, 1'b0, 4'hF, 32'h0, 32'h0);
    txn(1, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0);

    // Zero wait states with req_valid held high: accept every second cycle.
    for (int i = 0; i <= 8; i++) begin
      check($sformatf("thr_ready_%0d", i), 32'(req_ready[0]), 32'((i % 2) == 0));
      check($sformatf("thr_valid_%0d", i), 32'(rsp_valid[0]), 32'((i % 2) == 1));
      if (i < 8 && (i % 2) == 0) begin
        a = 32'h200 + 32'(i * 2);
        d = 32'hC0DE0000 + 32'(i);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_be[0] = 4'hF;
        dram_addr[0] = a; dram_data_out[0] = d;
        model[0][a[11:2]] = d;
      end else if (i == 8) begin
        req_valid[0] = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) txn(0, 1'b0, 4'hF, 32'h200 + 32'(i * 4), 32'h0);

    // A reset during WAIT abandons a pending write.
    txn(2, 1'b1, 4'hF, 32'h40, 32'h12345678);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_be[2] = 4'hF;
    dram_addr[2] = 32'h40; dram_data_out[2] = 32'h5A5A5A5A;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    @(negedge clk);
    check("abort_rst_valid", 32'(rsp_valid[2]), 32'h0);
    check("abort_rst_data", dram_data_in[2], 32'h0);
    @(negedge clk);
    rst[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("abort_no_rsp_%0d", i), 32'(rsp_valid[2]), 32'h0);
      @(negedge clk);
    end
    txn(2, 1'b0, 4'hF, 32'h40, 32'h0);

    // Random traffic across all three instances.
    for (int n = 0; n < 90; n++) begin
      int k;
      k = int'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) a = $urandom | 32'h0000_1000;
      else a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      txn(k, 1'($urandom), 4'($urandom), a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
